// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler: io_bus initiator that programs counter event selects,
// then sweeps all counters every SAMPLE_INTERVAL cycles and queues delta records.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cfg_enable          - high: program then sample; low: stop at next interval check
//   cfg_event_sel       - per-counter event selects, counter i at [i*EVENT_IDX_WIDTH +: EVENT_IDX_WIDTH]
//   io_bus_*            - master side: write_en, read_en, address, write_data out;
//                         read_data in (valid the cycle after read_en)
//   sample_valid/ready  - record FIFO head handshake
//   sample_seq/idx/delta- head record fields (0 when empty)
//   overrun_count       - dropped sweeps, saturating
//   busy                - high whenever not IDLE
module perf_counter_sampler #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0,
    parameter int          NUM_COUNTERS    = 4,
    parameter int          EVENT_IDX_WIDTH = 4,
    parameter int          SAMPLE_INTERVAL = 1024,
    parameter int          FIFO_DEPTH      = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cfg_enable,
    input  logic [NUM_COUNTERS*EVENT_IDX_WIDTH-1:0]   cfg_event_sel,
    output logic                                      io_bus_write_en,
    output logic                                      io_bus_read_en,
    output logic [31:0]                               io_bus_address,
    output logic [31:0]                               io_bus_write_data,
    input  logic [31:0]                               io_bus_read_data,
    output logic                                      sample_valid,
    input  logic                                      sample_ready,
    output logic [7:0]                                sample_seq,
    output logic [$clog2(NUM_COUNTERS)-1:0]           sample_idx,
    output logic [31:0]                               sample_delta,
    output logic [15:0]                               overrun_count,
    output logic                                      busy
);

    localparam int IDX_W = $clog2(NUM_COUNTERS);
    localparam int STP_W = IDX_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(SAMPLE_INTERVAL);
    localparam int REC_W = 8 + IDX_W + 32;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_INTERVAL - 1);
    localparam logic [STP_W-1:0] STP_LAST   = STP_W'(NUM_COUNTERS - 1);
    localparam logic [STP_W-1:0] STP_END    = STP_W'(NUM_COUNTERS);
    localparam logic [CNT_W-1:0] ADMIT_MAX  = CNT_W'(FIFO_DEPTH - NUM_COUNTERS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROGRAM = 3'd1;
    localparam logic [2:0] S_PRIME   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_SWEEP   = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [STP_W-1:0] step_q,    step_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [7:0]       seq_q,     seq_d;
    logic [15:0]      overrun_q, overrun_d;
    logic [31:0]      prev_q [NUM_COUNTERS];
    logic [31:0]      prev_d [NUM_COUNTERS];
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;

    logic                       push;
    logic                       pop;
    logic                       capture;
    logic [IDX_W-1:0]           cap_idx;
    logic [31:0]                cap_delta;
    logic [EVENT_IDX_WIDTH-1:0] cur_sel;
    logic                       reading;

    // Event select for the counter currently being programmed.
    always_comb begin
        cur_sel = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (step_q == STP_W'(i)) begin
                cur_sel = cfg_event_sel[i*EVENT_IDX_WIDTH +: EVENT_IDX_WIDTH];
            end
        end
    end

    // Read data arrives one cycle after its read, so the capture lags the
    // issue step by one; DRAIN and the final PRIME step catch the last counter.
    always_comb begin
        reading = (state_q == S_PRIME || state_q == S_SWEEP) && (step_q < STP_END);
        capture = ((state_q == S_PRIME || state_q == S_SWEEP) && (step_q != '0))
                  || (state_q == S_DRAIN);
        if (state_q == S_DRAIN) begin
            cap_idx = IDX_W'(NUM_COUNTERS - 1);
        end else begin
            cap_idx = IDX_W'(step_q - STP_W'(1));
        end
        cap_delta = io_bus_read_data - prev_q[cap_idx];
        push      = capture && (state_q != S_PRIME);
        push_rec  = {seq_q, cap_idx, cap_delta};
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        timer_d   = timer_q;
        seq_d     = seq_q;
        overrun_d = overrun_q;
        prev_d    = prev_q;

        io_bus_write_en   = 1'b0;
        io_bus_read_en    = 1'b0;
        io_bus_address    = '0;
        io_bus_write_data = '0;

        // Interval timer free-runs once programming is done.
        if (state_q != S_IDLE && state_q != S_PROGRAM) begin
            timer_d = (timer_q == '0) ? TMR_RELOAD : timer_q - TMR_W'(1);
        end

        if (reading) begin
            io_bus_read_en = 1'b1;
            io_bus_address = BASE_ADDRESS
                             + ((32'(NUM_COUNTERS) + 32'(step_q)) << 2);
        end

        if (capture) begin
            prev_d[cap_idx] = io_bus_read_data;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_enable) begin
                    state_d = S_PROGRAM;
                    step_d  = '0;
                end
            end
            S_PROGRAM: begin
                io_bus_write_en   = 1'b1;
                io_bus_address    = BASE_ADDRESS + (32'(step_q) << 2);
                io_bus_write_data = 32'(cur_sel);
                if (step_q == STP_LAST) begin
                    state_d = S_PRIME;
                    step_d  = '0;
                    timer_d = TMR_RELOAD;
                end else begin
                    step_d = step_q + STP_W'(1);
                end
            end
            S_PRIME: begin
                if (step_q == STP_END) begin
                    state_d = S_WAIT;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STP_W'(1);
                end
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    if (!cfg_enable) begin
                        state_d = S_IDLE;
                    end else if (count_q <= ADMIT_MAX) begin
                        state_d = S_SWEEP;
                        step_d  = '0;
                    end else if (overrun_q != 16'hFFFF) begin
                        overrun_d = overrun_q + 16'd1;
                    end
                end
            end
            S_SWEEP: begin
                if (step_q == STP_LAST) begin
                    state_d = S_DRAIN;
                end
                step_d = step_q + STP_W'(1);
            end
            S_DRAIN: begin
                state_d = S_WAIT;
                step_d  = '0;
                seq_d   = seq_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Admission leaves room for a whole sweep, so push never meets a full FIFO.
    always_comb begin
        pop      = (count_q != '0) && sample_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            timer_q   <= '0;
            seq_q     <= '0;
            overrun_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                prev_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prev_q    <= prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_rec;
        end
    end

    always_comb begin
        head_rec      = fifo_mem[rd_ptr_q];
        sample_valid  = (count_q != '0);
        sample_seq    = '0;
        sample_idx    = '0;
        sample_delta  = '0;
        if (sample_valid) begin
            {sample_seq, sample_idx, sample_delta} = head_rec;
        end
        overrun_count = overrun_q;
        busy          = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed bench for perf_counter_sampler with a registered-read counter slave.
// N=4, FIFO_DEPTH=8, SAMPLE_INTERVAL=16, BASE=0x40.
module tb_perf_counter_sampler;

    localparam logic [31:0] BASE = 32'h40;
    localparam int N   = 4;
    localparam int EW  = 4;
    localparam int SI  = 16;
    localparam int DEP = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_enable;
    logic [N*EW-1:0]   cfg_event_sel;
    logic              io_bus_write_en;
    logic              io_bus_read_en;
    logic [31:0]       io_bus_address;
    logic [31:0]       io_bus_write_data;
    logic [31:0]       io_bus_read_data = '0;
    logic              sample_valid;
    logic              sample_ready;
    logic [7:0]        sample_seq;
    logic [1:0]        sample_idx;
    logic [31:0]       sample_delta;
    logic [15:0]       overrun_count;
    logic              busy;

    logic [31:0] cnt [N];
    logic [31:0] off;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    perf_counter_sampler #(
        .BASE_ADDRESS(BASE), .NUM_COUNTERS(N), .EVENT_IDX_WIDTH(EW),
        .SAMPLE_INTERVAL(SI), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
        .cfg_event_sel(cfg_event_sel),
        .io_bus_write_en(io_bus_write_en), .io_bus_read_en(io_bus_read_en),
        .io_bus_address(io_bus_address), .io_bus_write_data(io_bus_write_data),
        .io_bus_read_data(io_bus_read_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_seq(sample_seq), .sample_idx(sample_idx),
        .sample_delta(sample_delta), .overrun_count(overrun_count),
        .busy(busy)
    );

    // Counter slave: count registers at BASE+0x10..0x1C, data one cycle later.
    always @(posedge clk) begin
        off = io_bus_address - BASE;
        if (io_bus_read_en && off >= 32'h10 && off <= 32'h1C) begin
            io_bus_read_data <= cnt[off[3:2]];
        end else if (io_bus_read_en) begin
            io_bus_read_data <= 32'hDEADBEEF;
        end else begin
            io_bus_read_data <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rd(input int exp_n, input string tag);
        int n = 0;
        while (!io_bus_read_en && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic sweep_reads(input string tag, input int drop_at);
        for (int k = 0; k < N; k++) begin
            if (k == drop_at) cfg_enable = 1'b0;
            check({tag, "_addr"},
                  (io_bus_read_en && !io_bus_write_en) ? io_bus_address : 32'hBAD,
                  BASE + 32'h10 + 32'(4 * k));
            tick();
        end
        check({tag, "_last"}, {io_bus_read_en, io_bus_write_en}, 0);
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] seq,
                             input logic [1:0] idx, input logic [31:0] dlt);
        sample_ready = 1'b1;
        check({tag, "_hdr"}, {sample_valid, sample_seq, sample_idx},
              {1'b1, seq, idx});
        check({tag, "_delta"}, sample_delta, dlt);
        tick();
    endtask

    task automatic bus_quiet(input int ncyc, input string tag);
        int act = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (io_bus_read_en || io_bus_write_en) act++;
            tick();
        end
        check(tag, act, 0);
    endtask

    logic [31:0] exp_d [8];

    initial begin
        reset         = 1'b1;
        cfg_enable    = 1'b0;
        cfg_event_sel = '0;
        sample_ready  = 1'b0;
        cnt[0] = 32'd10; cnt[1] = 32'd20;
        cnt[2] = 32'd100; cnt[3] = 32'hFFFFFFF0;
        repeat (3) tick();

        check("rst_ctl", {busy, sample_valid, io_bus_read_en, io_bus_write_en}, 0);
        check("rst_head", {sample_seq, sample_idx, overrun_count}, 0);
        check("rst_delta", sample_delta, 0);

        reset = 1'b0;
        tick();
        cfg_event_sel = {4'd3, 4'd2, 4'd1, 4'd0};
        cfg_enable = 1'b1;
        tick();

        // Program: one write per cycle, starting one cycle after enable.
        for (int i = 0; i < N; i++) begin
            check("prog_addr",
                  (io_bus_write_en && !io_bus_read_en) ? io_bus_address : 32'hBAD,
                  BASE + 32'(4 * i));
            check("prog_data", io_bus_write_data, i);
            tick();
        end

        sweep_reads("prime", -1);
        check("prime_nopush", sample_valid, 0);

        cnt[0] = 32'd15; cnt[1] = 32'd20; cnt[2] = 32'd350; cnt[3] = 32'h10;
        wait_rd(11, "interval1");
        sweep_reads("sweep1", -1);
        check("sweep1_cnt", {sample_valid, sample_seq, sample_idx}, {1'b1, 8'd0, 2'd0});

        cnt[0] = 32'd25; cnt[1] = 32'd21; cnt[2] = 32'd350; cnt[3] = 32'h30;
        wait_rd(11, "interval2");
        sweep_reads("sweep2", -1);

        // FIFO full: two admission checks drop their sweeps.
        cnt[0] = 32'd32; cnt[1] = 32'd21; cnt[2] = 32'd351; cnt[3] = 32'h40;
        bus_quiet(32, "overrun_quiet");
        check("overrun", overrun_count, 2);

        exp_d[0] = 32'd5;  exp_d[1] = 32'd0; exp_d[2] = 32'd250; exp_d[3] = 32'h20;
        exp_d[4] = 32'd10; exp_d[5] = 32'd1; exp_d[6] = 32'd0;   exp_d[7] = 32'h20;
        for (int j = 0; j < 8; j++) begin
            pop_check("drain", 8'(j / 4), 2'(j % 4), exp_d[j]);
        end
        sample_ready = 1'b0;
        check("empty_head", {sample_valid, sample_seq, sample_idx}, 0);
        check("empty_delta", sample_delta, 0);

        // Disable during sweep cycle 1: sweep completes, then IDLE.
        wait_rd(3, "interval3");
        sweep_reads("sweep3", 1);
        check("dis_busy", busy, 1);
        begin
            int n = 0;
            int rd = 0;
            while (busy && n < 50) begin
                if (io_bus_read_en || io_bus_write_en) rd++;
                tick();
                n++;
            end
            check("dis_to_idle", n, 11);
            check("dis_quiet", rd, 0);
        end
        pop_check("dis_r0", 8'd2, 2'd0, 32'd7);
        pop_check("dis_r1", 8'd2, 2'd1, 32'd0);
        pop_check("dis_r2", 8'd2, 2'd2, 32'd1);
        pop_check("dis_r3", 8'd2, 2'd3, 32'h10);
        sample_ready = 1'b0;
        bus_quiet(6, "idle_quiet");
        check("idle_busy", busy, 0);

        // Re-enable: re-program and re-prime; seq continues at 3.
        cfg_enable = 1'b1;
        wait_rd(5, "reprime_lat");
        sweep_reads("reprime", -1);
        cnt[0] = 32'd1032;
        wait_rd(11, "interval4");
        tick();
        tick();
        check("mid_hdr", {sample_valid, sample_seq, sample_idx}, {1'b1, 8'd3, 2'd0});
        check("mid_delta", sample_delta, 32'd1000);

        // Reset during sweep cycle 2.
        reset = 1'b1;
        cfg_enable = 1'b0;
        tick();
        check("rst2_ctl", {busy, sample_valid, io_bus_read_en, io_bus_write_en}, 0);
        check("rst2_head", {sample_seq, sample_idx, overrun_count}, 0);
        check("rst2_delta", sample_delta, 0);
        reset = 1'b0;
        tick();
        check("rst2_stay", {busy, sample_valid}, 0);

        // After reset seq restarts at 0.
        cfg_enable = 1'b1;
        wait_rd(5, "post_rst_lat");
        sweep_reads("post_prime", -1);
        cnt[0] = 32'd1050;
        wait_rd(11, "interval5");
        sweep_reads("post_sweep", -1);
        pop_check("post_r0", 8'd0, 2'd0, 32'd18);
        sample_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
